// File: rtl/trace_serializer.sv
// trace_serializer: turns accepted write-back records into one ASCII trace frame each.
// Optional TRACE_SPACES_EN macro emits the separator spaces around the kind and '<=' fields.
module trace_serializer #(
   parameter logic [7:0] IDLE_CHAR = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_kind,
   input  logic [15:0] in_time,
   input  logic [31:0] in_pc,
   input  logic [4:0]  in_reg,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   output logic [7:0]  out_char,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] frame_cnt
);
   typedef enum logic [3:0] {
      ST_IDLE, ST_CARET, ST_TIME, ST_AT, ST_PC, ST_COLON, ST_SP1, ST_KIND,
      ST_REG, ST_ADDR, ST_SP2, ST_LT, ST_EQ, ST_SP3, ST_DATA, ST_HASH
   } state_t;
`ifdef TRACE_SPACES_EN
   localparam bit SPACES = 1'b1;
`else
   localparam bit SPACES = 1'b0;
`endif
   state_t state, state_nxt;
   logic [3:0] idx, idx_init, time_start, hex_nib;
   logic kind_q, adv, last;
   logic [15:0] time_q;
   logic [31:0] pc_q, addr_q, data_q;
   logic [4:0] reg_q, reg_base, reg_ones;
   logic [1:0] reg_tens;

   function automatic logic [7:0] hex(input logic [3:0] n);
      return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
   endfunction

   // Non-decimal BCD nibbles are stored as zero so suppression and printing agree.
   function automatic logic [15:0] bcd_clean(input logic [15:0] t);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) r[4*i +: 4] = t[4*i +: 4] > 4'd9 ? 4'd0 : t[4*i +: 4];
      return r;
   endfunction

   assign adv = (state != ST_IDLE) && out_ready;
   assign last = idx == 4'd0;
   assign time_start = time_q[15:12] != 4'd0 ? 4'd3 : time_q[11:8] != 4'd0 ? 4'd2 :
                       time_q[7:4] != 4'd0 ? 4'd1 : 4'd0;
   assign reg_tens = reg_q >= 5'd30 ? 2'd3 : reg_q >= 5'd20 ? 2'd2 : reg_q >= 5'd10 ? 2'd1 : 2'd0;
   assign reg_base = reg_q >= 5'd30 ? 5'd30 : reg_q >= 5'd20 ? 5'd20 : reg_q >= 5'd10 ? 5'd10 : 5'd0;
   assign reg_ones = reg_q - reg_base;
   assign idx_init = state_nxt == ST_TIME ? time_start :
                     (state_nxt inside {ST_PC, ST_ADDR, ST_DATA}) ? 4'd7 :
                     (state_nxt == ST_REG && reg_q >= 5'd10) ? 4'd1 : 4'd0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx <= 4'd0;
         frame_cnt <= 16'd0;
         kind_q <= 1'b0;
         time_q <= 16'd0;
         pc_q <= 32'd0;
         reg_q <= 5'd0;
         addr_q <= 32'd0;
         data_q <= 32'd0;
      end else begin
         if (in_valid && in_ready) begin
            kind_q <= in_kind;
            time_q <= bcd_clean(in_time);
            pc_q <= in_pc;
            reg_q <= in_reg;
            addr_q <= in_addr;
            data_q <= in_data;
         end
         if (adv) idx <= state_nxt == state ? idx - 4'd1 : idx_init;
         if (adv && state == ST_HASH) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == ST_IDLE) state_nxt = in_valid ? ST_CARET : ST_IDLE;
      else if (adv)
         case (state)
            ST_CARET: state_nxt = ST_TIME;
            ST_TIME:  state_nxt = last ? ST_AT : ST_TIME;
            ST_AT:    state_nxt = ST_PC;
            ST_PC:    state_nxt = last ? ST_COLON : ST_PC;
            ST_COLON: state_nxt = SPACES ? ST_SP1 : ST_KIND;
            ST_SP1:   state_nxt = ST_KIND;
            ST_KIND:  state_nxt = kind_q ? ST_ADDR : ST_REG;
            ST_REG, ST_ADDR: state_nxt = !last ? state : SPACES ? ST_SP2 : ST_LT;
            ST_SP2:   state_nxt = ST_LT;
            ST_LT:    state_nxt = ST_EQ;
            ST_EQ:    state_nxt = SPACES ? ST_SP3 : ST_DATA;
            ST_SP3:   state_nxt = ST_DATA;
            ST_DATA:  state_nxt = last ? ST_HASH : ST_DATA;
            default:  state_nxt = ST_IDLE;
         endcase
   end

   always_comb begin
      in_ready = state == ST_IDLE;
      out_valid = state != ST_IDLE;
      hex_nib = state == ST_PC ? pc_q[idx[2:0]*4 +: 4] :
                state == ST_ADDR ? addr_q[idx[2:0]*4 +: 4] : data_q[idx[2:0]*4 +: 4];
      case (state)
         ST_CARET: out_char = "^";
         ST_TIME:  out_char = 8'h30 + {4'h0, time_q[idx[1:0]*4 +: 4]};
         ST_AT:    out_char = "@";
         ST_PC, ST_ADDR, ST_DATA: out_char = hex(hex_nib);
         ST_COLON: out_char = ":";
         ST_SP1, ST_SP2, ST_SP3: out_char = " ";
         ST_KIND:  out_char = kind_q ? "*" : "$";
         ST_REG:   out_char = idx[0] ? 8'h30 + {6'h0, reg_tens} : 8'h30 + {3'h0, reg_ones};
         ST_LT:    out_char = "<";
         ST_EQ:    out_char = "=";
         ST_HASH:  out_char = "#";
         default:  out_char = IDLE_CHAR;
      endcase
   end
endmodule
